// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN output-path blocks: checker state
// encoding, RGB565 field positions and the default image geometry.
package cnn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } chkState_t;

  localparam int RED_HI = 15;
  localparam int RED_LO = 11;
  localparam int GRN_HI = 10;
  localparam int GRN_LO = 5;
  localparam int BLU_HI = 4;
  localparam int BLU_LO = 0;

  localparam int DEFAULT_IMG_W = 480;
  localparam int DEFAULT_IMG_H = 272;

endpackage

// File: rtl/pix_match.sv
// Combinational per-pixel comparator for frame_stream_checker.
// With FRAME_CHK_TOL_EN defined, each RGB565 channel may differ by up to
// TOL; otherwise pixels must be bit-exact.
module pix_match
  import cnn_pkg::*;
#(
  parameter int PIX_W = 16,
  parameter int TOL   = 1
) (
  input  logic [PIX_W-1:0] expPix,
  input  logic [PIX_W-1:0] gotPix,
  output logic             isMatch
);

`ifdef FRAME_CHK_TOL_EN
  logic [RED_HI-RED_LO+1:0] redDiff;
  logic [GRN_HI-GRN_LO+1:0] grnDiff;
  logic [BLU_HI-BLU_LO+1:0] bluDiff;

  // Absolute channel differences, computed one bit wider than each field
  // by always subtracting the smaller value from the larger one.
  always_comb begin
    redDiff = (expPix[RED_HI:RED_LO] >= gotPix[RED_HI:RED_LO]) ?
              {1'b0, expPix[RED_HI:RED_LO]} - {1'b0, gotPix[RED_HI:RED_LO]} :
              {1'b0, gotPix[RED_HI:RED_LO]} - {1'b0, expPix[RED_HI:RED_LO]};
    grnDiff = (expPix[GRN_HI:GRN_LO] >= gotPix[GRN_HI:GRN_LO]) ?
              {1'b0, expPix[GRN_HI:GRN_LO]} - {1'b0, gotPix[GRN_HI:GRN_LO]} :
              {1'b0, gotPix[GRN_HI:GRN_LO]} - {1'b0, expPix[GRN_HI:GRN_LO]};
    bluDiff = (expPix[BLU_HI:BLU_LO] >= gotPix[BLU_HI:BLU_LO]) ?
              {1'b0, expPix[BLU_HI:BLU_LO]} - {1'b0, gotPix[BLU_HI:BLU_LO]} :
              {1'b0, gotPix[BLU_HI:BLU_LO]} - {1'b0, expPix[BLU_HI:BLU_LO]};
  end

  assign isMatch = (redDiff <= (RED_HI-RED_LO+2)'(TOL)) &&
                   (grnDiff <= (GRN_HI-GRN_LO+2)'(TOL)) &&
                   (bluDiff <= (BLU_HI-BLU_LO+2)'(TOL));
`else
  // Exact comparison; a negative TOL is treated as "nothing can match".
  assign isMatch = (expPix == gotPix) && (TOL >= 0);
`endif

endmodule

// File: rtl/frame_stream_checker.sv
// Streaming frame checker: compares the RGB565 pixel stream against an
// external golden ROM (1-cycle read latency) at one pixel per clock and
// reports per-line and per-frame mismatch results plus the first mismatch.
// Optional per-channel tolerance: define FRAME_CHK_TOL_EN (see pix_match).
module frame_stream_checker
  import cnn_pkg::*;
#(
  parameter int IMG_W  = DEFAULT_IMG_W,
  parameter int IMG_H  = DEFAULT_IMG_H,
  parameter int PIX_W  = 16,
  parameter int ADDR_W = 17,
  parameter int TOL    = 1
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iStart,
  input  logic              iPixValid,
  input  logic [PIX_W-1:0]  iPixData,
  output logic              oPixReady,
  output logic [ADDR_W-1:0] oGoldAddr,
  input  logic [PIX_W-1:0]  iGoldData,
  output logic              oBusy,
  output logic              oLineDone,
  output logic [8:0]        oLineIdx,
  output logic [8:0]        oLineErrCnt,
  output logic [ADDR_W-1:0] oErrCnt,
  output logic [ADDR_W-1:0] oFirstErrIdx,
  output logic [PIX_W-1:0]  oFirstErrExp,
  output logic [PIX_W-1:0]  oFirstErrGot,
  output logic              oDone,
  output logic              oPass
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(IMG_W*IMG_H-1);
  localparam logic [8:0]        LAST_COL = 9'(IMG_W-1);

  chkState_t state, nextState;

  logic              accept;
  logic              startNow;
  logic [ADDR_W-1:0] rIdx;
  logic [8:0]        rCol;
  logic [8:0]        rLine;

  logic              sValid;
  logic [PIX_W-1:0]  sPix;
  logic [ADDR_W-1:0] sIdx;
  logic [8:0]        sCol;
  logic [8:0]        sLine;

  logic              pixMatch;
  logic              mismatch;
  logic [8:0]        rLineErr;
  logic [8:0]        lineCntNext;
  logic              rFirstSeen;
  logic              rPassValid;

  assign oPixReady   = (state == RUN);
  assign oBusy       = (state == RUN) || (state == DRAIN);
  assign accept      = iPixValid && oPixReady;
  assign startNow    = iStart && ((state == IDLE) || (state == DONE));
  assign oGoldAddr   = rIdx;
  assign mismatch    = sValid && !pixMatch;
  assign lineCntNext = rLineErr + 9'(mismatch);
  assign oPass       = rPassValid && (oErrCnt == '0);

  // State register.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) state <= IDLE;
    else      state <= nextState;
  end

  // Next-state logic: start from IDLE/DONE, leave RUN after the last pixel
  // of the frame, then spend one cycle draining the compare stage.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (iStart) nextState = RUN;
      RUN:     if (accept && (rIdx == LAST_IDX)) nextState = DRAIN;
      DRAIN:   nextState = DONE;
      DONE:    if (iStart) nextState = RUN;
      default: nextState = IDLE;
    endcase
  end

  // Pixel position tracking and the one-cycle stage that waits for the ROM.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      rIdx   <= '0;
      rCol   <= '0;
      rLine  <= '0;
      sValid <= 1'b0;
      sPix   <= '0;
      sIdx   <= '0;
      sCol   <= '0;
      sLine  <= '0;
    end else if (startNow) begin
      rIdx   <= '0;
      rCol   <= '0;
      rLine  <= '0;
      sValid <= 1'b0;
    end else begin
      sValid <= accept;
      if (accept) begin
        sPix  <= iPixData;
        sIdx  <= rIdx;
        sCol  <= rCol;
        sLine <= rLine;
        rIdx  <= (rIdx == LAST_IDX) ? '0 : rIdx + 1'b1;
        if (rCol == LAST_COL) begin
          rCol  <= '0;
          rLine <= rLine + 1'b1;
        end else begin
          rCol <= rCol + 1'b1;
        end
      end
    end
  end

  pix_match #(
    .PIX_W (PIX_W),
    .TOL   (TOL)
  ) uPixMatch (
    .expPix  (iGoldData),
    .gotPix  (sPix),
    .isMatch (pixMatch)
  );

  // Result bookkeeping: line/frame error counts, first-mismatch capture,
  // line-done and frame-done pulses.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      rLineErr     <= '0;
      rFirstSeen   <= 1'b0;
      rPassValid   <= 1'b0;
      oErrCnt      <= '0;
      oFirstErrIdx <= '0;
      oFirstErrExp <= '0;
      oFirstErrGot <= '0;
      oLineDone    <= 1'b0;
      oLineIdx     <= '0;
      oLineErrCnt  <= '0;
      oDone        <= 1'b0;
    end else if (startNow) begin
      rLineErr     <= '0;
      rFirstSeen   <= 1'b0;
      rPassValid   <= 1'b0;
      oErrCnt      <= '0;
      oFirstErrIdx <= '0;
      oFirstErrExp <= '0;
      oFirstErrGot <= '0;
      oLineDone    <= 1'b0;
      oLineIdx     <= '0;
      oLineErrCnt  <= '0;
      oDone        <= 1'b0;
    end else begin
      oDone     <= (state == DRAIN);
      oLineDone <= 1'b0;
      if (state == DRAIN) rPassValid <= 1'b1;
      if (sValid) begin
        if (mismatch) begin
          if (oErrCnt != '1) oErrCnt <= oErrCnt + 1'b1;
          if (!rFirstSeen) begin
            rFirstSeen   <= 1'b1;
            oFirstErrIdx <= sIdx;
            oFirstErrExp <= iGoldData;
            oFirstErrGot <= sPix;
          end
        end
        if (sCol == LAST_COL) begin
          oLineDone   <= 1'b1;
          oLineIdx    <= sLine;
          oLineErrCnt <= lineCntNext;
          rLineErr    <= '0;
        end else begin
          rLineErr <= lineCntNext;
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_stream_checker.sv
// Directed testbench for frame_stream_checker on a 4x2 image whose golden
// ROM holds 0x0000..0x0007. Tolerance expectations follow FRAME_CHK_TOL_EN.
module tb_frame_stream_checker;

  localparam int IMG_W  = 4;
  localparam int IMG_H  = 2;
  localparam int PIX_W  = 16;
  localparam int ADDR_W = 4;
  localparam int TOL    = 1;

  typedef logic [15:0] frame_t [8];
  typedef int gaps_t [8];

  logic              iClk = 1'b0;
  logic              iRst;
  logic              iStart;
  logic              iPixValid;
  logic [PIX_W-1:0]  iPixData;
  logic              oPixReady;
  logic [ADDR_W-1:0] oGoldAddr;
  logic [PIX_W-1:0]  iGoldData;
  logic              oBusy;
  logic              oLineDone;
  logic [8:0]        oLineIdx;
  logic [8:0]        oLineErrCnt;
  logic [ADDR_W-1:0] oErrCnt;
  logic [ADDR_W-1:0] oFirstErrIdx;
  logic [PIX_W-1:0]  oFirstErrExp;
  logic [PIX_W-1:0]  oFirstErrGot;
  logic              oDone;
  logic              oPass;

  int testsRun    = 0;
  int testsFailed = 0;
  int lineIdxQ[$];
  int lineErrQ[$];

  frame_t cleanFrame;
  gaps_t  noGaps;

  frame_stream_checker #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .PIX_W  (PIX_W),
    .ADDR_W (ADDR_W),
    .TOL    (TOL)
  ) dut (
    .iClk         (iClk),
    .iRst         (iRst),
    .iStart       (iStart),
    .iPixValid    (iPixValid),
    .iPixData     (iPixData),
    .oPixReady    (oPixReady),
    .oGoldAddr    (oGoldAddr),
    .iGoldData    (iGoldData),
    .oBusy        (oBusy),
    .oLineDone    (oLineDone),
    .oLineIdx     (oLineIdx),
    .oLineErrCnt  (oLineErrCnt),
    .oErrCnt      (oErrCnt),
    .oFirstErrIdx (oFirstErrIdx),
    .oFirstErrExp (oFirstErrExp),
    .oFirstErrGot (oFirstErrGot),
    .oDone        (oDone),
    .oPass        (oPass)
  );

  always #5 iClk = ~iClk;

  // Golden ROM model: content equals address, one-cycle read latency.
  always @(posedge iClk) iGoldData <= 16'(oGoldAddr);

  // Record every line-done pulse for later inspection.
  always @(negedge iClk) begin
    if (oLineDone) begin
      lineIdxQ.push_back(int'(oLineIdx));
      lineErrQ.push_back(int'(oLineErrCnt));
    end
  end

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic startFrame();
    iStart = 1'b1;
    lineIdxQ.delete();
    lineErrQ.delete();
    tick();
    iStart = 1'b0;
  endtask

  task automatic streamFrame(input frame_t pix, input gaps_t gaps,
                             input int first, input int last);
    for (int i = first; i < last; i++) begin
      iPixValid = 1'b0;
      repeat (gaps[i]) tick();
      iPixValid = 1'b1;
      iPixData  = pix[i];
      tick();
    end
    iPixValid = 1'b0;
  endtask

  // Counts falling edges until oDone, bounded so the bench cannot hang.
  task automatic waitDone(output int n);
    n = 0;
    while (!oDone && n < 20) begin
      @(negedge iClk);
      n++;
    end
  endtask

  task automatic runFrame(input frame_t pix, input gaps_t gaps, output int lat);
    startFrame();
    streamFrame(pix, gaps, 0, 8);
    waitDone(lat);
    tick();
  endtask

  task automatic test_reset();
    iRst = 1'b1;
    repeat (2) tick();
    testsRun++;
    if ({oPixReady, oBusy, oLineDone, oDone, oPass, oGoldAddr, oLineIdx, oLineErrCnt,
         oErrCnt, oFirstErrIdx, oFirstErrExp, oFirstErrGot} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs: ready=%b busy=%b done=%b pass=%b err=%0d addr=%0d, required all 0",
               oPixReady, oBusy, oDone, oPass, oErrCnt, oGoldAddr);
    end
    iRst = 1'b0;
    tick();
    testsRun++;
    if ({oPixReady, oBusy} !== 2'b00) begin
      testsFailed++;
      $display("[TB] FAIL idle_after_reset: ready/busy=%b, required 00", {oPixReady, oBusy});
    end
  endtask

  task automatic test_clean_frame();
    int lat;
    startFrame();
    testsRun++;
    if ({oPixReady, oBusy} !== 2'b11) begin
      testsFailed++;
      $display("[TB] FAIL run_ready_busy: got %b, required 11", {oPixReady, oBusy});
    end
    streamFrame(cleanFrame, noGaps, 0, 8);
    waitDone(lat);
    testsRun++;
    if (lat !== 2) begin
      testsFailed++;
      $display("[TB] FAIL clean_done_latency: got %0d cycles, required 2", lat);
    end
    tick();
    testsRun++;
    if ({oPass, oErrCnt, oDone, oBusy, oFirstErrIdx} !== {1'b1, 4'd0, 1'b0, 1'b0, 4'd0}) begin
      testsFailed++;
      $display("[TB] FAIL clean_result: pass=%b err=%0d done=%b busy=%b first=%0d, required 1 0 0 0 0",
               oPass, oErrCnt, oDone, oBusy, oFirstErrIdx);
    end
    testsRun++;
    if (lineIdxQ.size() != 2) begin
      testsFailed++;
      $display("[TB] FAIL clean_line_pulses: got %0d, required 2", lineIdxQ.size());
    end else if ({lineIdxQ[0], lineIdxQ[1], lineErrQ[0], lineErrQ[1]} != {32'd0, 32'd1, 32'd0, 32'd0}) begin
      testsFailed++;
      $display("[TB] FAIL clean_line_pulses: idx %0d,%0d err %0d,%0d, required idx 0,1 err 0,0",
               lineIdxQ[0], lineIdxQ[1], lineErrQ[0], lineErrQ[1]);
    end
  endtask

  task automatic test_errors();
    frame_t pix;
    int lat;
    pix    = cleanFrame;
    pix[2] = 16'h00FF;
    pix[5] = 16'h1234;
    runFrame(pix, noGaps, lat);
    testsRun++;
    if ({oPass, oErrCnt} !== {1'b0, 4'd2}) begin
      testsFailed++;
      $display("[TB] FAIL err_count: pass=%b err=%0d, required pass=0 err=2", oPass, oErrCnt);
    end
    testsRun++;
    if ({oFirstErrIdx, oFirstErrExp, oFirstErrGot} !== {4'd2, 16'h0002, 16'h00FF}) begin
      testsFailed++;
      $display("[TB] FAIL first_err: idx=%0d exp=%h got=%h, required 2 0002 00ff",
               oFirstErrIdx, oFirstErrExp, oFirstErrGot);
    end
    testsRun++;
    if (lineErrQ.size() != 2) begin
      testsFailed++;
      $display("[TB] FAIL err_line_counts: got %0d pulses, required 2", lineErrQ.size());
    end else if ({lineErrQ[0], lineErrQ[1]} != {32'd1, 32'd1}) begin
      testsFailed++;
      $display("[TB] FAIL err_line_counts: got %0d,%0d, required 1,1", lineErrQ[0], lineErrQ[1]);
    end
  endtask

  task automatic test_gaps();
    gaps_t gaps;
    int lat;
    gaps = '{0, 2, 1, 0, 3, 0, 1, 2};
    startFrame();
    for (int i = 0; i < 8; i++) begin
      iPixValid = 1'b0;
      for (int g = 0; g < gaps[i]; g++) begin
        testsRun++;
        if (oGoldAddr !== ADDR_W'(i)) begin
          testsFailed++;
          $display("[TB] FAIL gap_addr_hold: pixel %0d addr=%0d, required %0d", i, oGoldAddr, i);
        end
        tick();
      end
      iPixValid = 1'b1;
      iPixData  = cleanFrame[i];
      tick();
    end
    iPixValid = 1'b0;
    waitDone(lat);
    testsRun++;
    if (lat !== 2) begin
      testsFailed++;
      $display("[TB] FAIL gap_done_latency: got %0d, required 2", lat);
    end
    tick();
    testsRun++;
    if ({oPass, oErrCnt, lineIdxQ.size()} !== {1'b1, 4'd0, 32'd2}) begin
      testsFailed++;
      $display("[TB] FAIL gap_result: pass=%b err=%0d lines=%0d, required 1 0 2",
               oPass, oErrCnt, lineIdxQ.size());
    end
  endtask

  task automatic test_reset_midframe();
    frame_t pix;
    int lat;
    pix    = cleanFrame;
    pix[1] = 16'hBEEF;
    startFrame();
    streamFrame(pix, noGaps, 0, 3);
    testsRun++;
    if ({oErrCnt, oFirstErrIdx} !== {4'd1, 4'd1}) begin
      testsFailed++;
      $display("[TB] FAIL midframe_err: err=%0d first=%0d, required 1 1", oErrCnt, oFirstErrIdx);
    end
    iRst = 1'b1;
    #2;
    testsRun++;
    if ({oPixReady, oBusy, oLineDone, oDone, oPass, oGoldAddr, oLineIdx, oLineErrCnt,
         oErrCnt, oFirstErrIdx, oFirstErrExp, oFirstErrGot} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL midframe_reset: ready=%b busy=%b err=%0d addr=%0d first=%0d got=%h, required all 0",
               oPixReady, oBusy, oErrCnt, oGoldAddr, oFirstErrIdx, oFirstErrGot);
    end
    tick();
    iRst = 1'b0;
    tick();
    runFrame(cleanFrame, noGaps, lat);
    testsRun++;
    if ({oPass, oErrCnt, lat} !== {1'b1, 4'd0, 32'd2}) begin
      testsFailed++;
      $display("[TB] FAIL rerun_after_reset: pass=%b err=%0d lat=%0d, required 1 0 2", oPass, oErrCnt, lat);
    end
  endtask

  task automatic test_tolerance();
    frame_t pix;
    int lat;
    logic [3:0] expErr;
`ifdef FRAME_CHK_TOL_EN
    expErr = 4'd0;
`else
    expErr = 4'd1;
`endif
    pix    = cleanFrame;
    pix[3] = 16'h0804;
    runFrame(pix, noGaps, lat);
    testsRun++;
    if ({oErrCnt, oPass} !== {expErr, expErr == 4'd0}) begin
      testsFailed++;
      $display("[TB] FAIL tol_within: err=%0d pass=%b, required err=%0d", oErrCnt, oPass, expErr);
    end
    pix[3] = 16'h0005;
    runFrame(pix, noGaps, lat);
    testsRun++;
    if ({oErrCnt, oPass, oFirstErrGot} !== {4'd1, 1'b0, 16'h0005}) begin
      testsFailed++;
      $display("[TB] FAIL tol_outside: err=%0d pass=%b got=%h, required 1 0 0005", oErrCnt, oPass, oFirstErrGot);
    end
  endtask

  task automatic test_start_ignored();
    frame_t pix;
    int lat;
    pix    = cleanFrame;
    pix[6] = 16'h0F0F;
    startFrame();
    streamFrame(pix, noGaps, 0, 4);
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    testsRun++;
    if ({oBusy, oGoldAddr} !== {1'b1, 4'd4}) begin
      testsFailed++;
      $display("[TB] FAIL start_in_run: busy=%b addr=%0d, required 1 4", oBusy, oGoldAddr);
    end
    streamFrame(pix, noGaps, 4, 8);
    waitDone(lat);
    tick();
    testsRun++;
    if ({oErrCnt, oFirstErrIdx, oPass, lineErrQ.size()} !== {4'd1, 4'd6, 1'b0, 32'd2}) begin
      testsFailed++;
      $display("[TB] FAIL start_ignored_result: err=%0d first=%0d pass=%b lines=%0d, required 1 6 0 2",
               oErrCnt, oFirstErrIdx, oPass, lineErrQ.size());
    end
    startFrame();
    testsRun++;
    if ({oErrCnt, oFirstErrIdx, oFirstErrGot, oPass, oPixReady} !== {4'd0, 4'd0, 16'h0, 1'b0, 1'b1}) begin
      testsFailed++;
      $display("[TB] FAIL restart_clear: err=%0d first=%0d got=%h pass=%b ready=%b, required 0 0 0000 0 1",
               oErrCnt, oFirstErrIdx, oFirstErrGot, oPass, oPixReady);
    end
    streamFrame(cleanFrame, noGaps, 0, 8);
    waitDone(lat);
    tick();
    testsRun++;
    if ({oPass, oErrCnt, lat} !== {1'b1, 4'd0, 32'd2}) begin
      testsFailed++;
      $display("[TB] FAIL restart_result: pass=%b err=%0d lat=%0d, required 1 0 2", oPass, oErrCnt, lat);
    end
  endtask

  // Scenario sequence.
  initial begin
    iRst      = 1'b1;
    iStart    = 1'b0;
    iPixValid = 1'b0;
    iPixData  = '0;
    for (int i = 0; i < 8; i++) begin
      cleanFrame[i] = 16'(i);
      noGaps[i]     = 0;
    end
    test_reset();
    test_clean_frame();
    test_errors();
    test_gaps();
    test_reset_midframe();
    test_tolerance();
    test_start_ignored();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/frame_stream_checker.md
# frame_stream_checker

- Synthesizable, parametrised frame checker for the CNN output path.
- Taps the RGB565 pixel stream leaving the RGB888→RGB565 stage and compares each pixel against a golden image held in an on-chip ROM.
- Reports per-line and per-frame results, captures the first mismatch, and compares at one pixel per clock.
- Replaces the simulation-only full-buffer comparison with a streaming check that runs on FPGA.

## Interface
Parameters:
- IMG_W, 480, pixels per line
- IMG_H, 272, lines per frame
- PIX_W, 16, pixel width in bits (must be 16 when tolerance is compiled in)
- ADDR_W, 17, golden ROM address width; must satisfy 2^ADDR_W ≥ IMG_W*IMG_H
- TOL, 1, per-channel absolute tolerance (used only with tolerance compiled in)

Ports (one clock `iClk`; reset `iRst` is asynchronous and active-high):
- iClk  in  1  system clock
- iRst  in  1  asynchronous active-high reset
- iStart  in  1  starts a frame check; sampled only in IDLE or DONE
- iPixValid  in  1  pixel present on iPixData
- iPixData  in  PIX_W  pixel under test
- oPixReady  out  1  high only in RUN; a pixel is accepted when iPixValid & oPixReady
- oGoldAddr  out  ADDR_W  golden ROM read address (ROM read latency is exactly 1 cycle)
- iGoldData  in  PIX_W  golden pixel returned for the previous cycle's oGoldAddr
- oBusy  out  1  high in RUN and DRAIN
- oLineDone  out  1  one-cycle pulse after the last pixel of a line is compared
- oLineIdx  out  9  index of the line just completed
- oLineErrCnt  out  9  mismatches in the line just completed
- oErrCnt  out  ADDR_W  frame mismatch count; saturates at all-ones
- oFirstErrIdx  out  ADDR_W  linear index of the first mismatch
- oFirstErrExp  out  PIX_W  golden value at the first mismatch
- oFirstErrGot  out  PIX_W  DUT value at the first mismatch
- oDone  out  1  one-cycle pulse at frame end
- oPass  out  1  valid from oDone until the next iStart; high iff oErrCnt == 0

## Operation
States and transitions:
- IDLE: iStart → RUN. Clears the pixel index, column, line, all counters and the first-error capture.
- RUN: each accepted pixel has index rIdx; oGoldAddr = rIdx combinationally in the same cycle. After accepting pixel IMG_W*IMG_H−1 → DRAIN.
- DRAIN: one cycle; completes the final compare → DONE.
- DONE: asserts oDone for one cycle. Holds oPass, oErrCnt and the first-error registers. iStart → RUN, with the same clearing as from IDLE.

Compare stage:
- Registers {valid, pixel, index, column, line} for one cycle, then compares against iGoldData.
- A mismatch increments the line and frame counters.
- The first mismatch only (flag set) loads the oFirstErr* registers.
- When column == IMG_W−1: pulse oLineDone with the final line count, including the current pixel; then clear the internal line counter.

Rules:
- iStart during RUN or DRAIN is ignored.
- Gaps in iPixValid are allowed. The index advances only on accept.
- Column wraps IMG_W−1 → 0 and the line then increments.
- oFirstErr* read zero when no error has occurred.
- Reset mid-frame returns to IDLE, with every output and counter at zero. oPixReady = 0.

## Timing
- Reset values: all outputs 0.
- Pixel accepted in cycle t:
  - oGoldAddr valid in t; iGoldData sampled in t+1.
  - Counters, first-error registers and oLineDone are registered, visible in t+2.
- Last pixel accepted in cycle t: DRAIN in t+1, oDone and final oPass in t+2, DONE state from t+2.
- Throughput: one pixel per clock with no bubbles. oPixReady does not depend on iPixValid.

## Configuration
- `FRAME_CHK_TOL_EN` defined: pixels are split into RGB565 fields R[15:11], G[10:5], B[4:0]. A pixel matches when |exp−got| ≤ TOL in every channel, using unsigned subtraction one bit wider than the field.
- Undefined: a pixel matches only on exact PIX_W-bit equality. TOL is unused.

## Structure
- Shared package `cnn_pkg` holds:
  - state encoding (IDLE, RUN, DRAIN, DONE)
  - RGB565 field positions
  - the default IMG_W/IMG_H constants.
- One sub-module, `pix_match`: combinational per-pixel comparator. It is the only place the `FRAME_CHK_TOL_EN` macro is evaluated.
- The golden ROM is external, loaded from the team's RGB565 hex image.

## Test plan
Parameters IMG_W=4, IMG_H=2, ROM = 0x0000..0x0007:
1. Stream 0x0000..0x0007 back to back → oDone in cycle t+2 after the last accept; oPass=1, oErrCnt=0; two oLineDone pulses with oLineErrCnt=0 and oLineIdx 0, 1.
2. Corrupt pixels 2 (0x00FF) and 5 (0x1234) → oErrCnt=2, oLineErrCnt 1 then 1, oFirstErrIdx=2, oFirstErrExp=0x0002, oFirstErrGot=0x00FF, oPass=0.
3. Insert random iPixValid gaps, all pixels correct → same result as scenario 1; oGoldAddr increments only on accept.
4. Assert iRst mid-frame after 3 pixels → all outputs 0 and IDLE. A new iStart then re-checks from index 0 → pass.
5. With `FRAME_CHK_TOL_EN`, TOL=1, pixel 3 sent as 0x0804 (R+1, B+1) → counted as a match, pass. Sending 0x0005 (B+2) → 1 error.
6. Send iStart during RUN → ignored. A second iStart in DONE restarts cleanly with counters cleared.
